// File: rtl/uart_cfg_pkg.sv
// Shared types and helpers for the configurable UART receiver.
//   parity_e     - decoded parity mode (raw code 3 decodes to PAR_NONE)
//   rx_state_e   - receiver FSM states
//   rx_status_t  - error/status flags that travel with each received word
package uart_cfg_pkg;

    localparam int DATA_BITS_MIN = 5;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic brk;
    } rx_status_t;

    function automatic parity_e decode_parity(input logic [1:0] raw);
        case (raw)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] raw, input int max_bits);
        if (int'(raw) < DATA_BITS_MIN) return 4'(DATA_BITS_MIN);
        if (int'(raw) > max_bits)      return 4'(max_bits);
        return raw;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Valid/ready stream carrying one received word plus its error flags.
//   out_valid       - word available (producer)
//   out_ready       - consumer accepts when out_valid && out_ready
//   out_data        - received data, LSB first on the line, unused upper bits zero
//   out_parity_err  - parity mismatch
//   out_frame_err   - a stop bit sampled low
//   out_break       - break frame
interface uart_rx_cfg_if #(
    parameter int MAX_DATA_BITS = 9
) ();

    logic                     out_valid;
    logic                     out_ready;
    logic [MAX_DATA_BITS-1:0] out_data;
    logic                     out_parity_err;
    logic                     out_frame_err;
    logic                     out_break;

    modport master (
        output out_valid, out_data, out_parity_err, out_frame_err, out_break,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_parity_err, out_frame_err, out_break,
        output out_ready
    );

endinterface

// File: rtl/uart_bit_sampler.sv
// Input synchroniser, oversampling tick counter and 3-sample majority vote.
//   clk, rst      - clock, synchronous active-high reset
//   tick          - oversampling enable, OVERSAMPLE per bit
//   rx            - asynchronous serial input
//   restart       - realign the counter (start edge seen); counter reads 0 afterwards
//   rxs           - synchronised rx
//   bit_value     - 2-of-3 majority, valid while bit_strobe is high
//   bit_strobe    - tick on which the majority of the current bit is decided
//   bit_boundary  - tick on which the counter wraps into the next bit
module uart_bit_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic rx,
    input  logic restart,
    output logic rxs,
    output logic bit_value,
    output logic bit_strobe,
    output logic bit_boundary
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] S_FIRST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_LAST  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] S_WRAP  = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          s;
    logic                   samp_a;
    logic                   samp_b;

    // NOTE: non-blocking assignments in clocked blocks so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchroniser resets to idle-high so reset release never mimics a start bit.
            sync_q <= '1;
            s      <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (restart)
                s <= '0;
            else if (tick)
                s <= (s == S_WRAP) ? '0 : s + 1'b1;
            if (tick && s == S_FIRST) samp_a <= rxs;
            if (tick && s == S_MID)   samp_b <= rxs;
        end
    end

    assign rxs          = sync_q[SYNC_STAGES-1];
    // Third sample is taken live on the deciding tick.
    assign bit_value    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign bit_strobe   = tick && (s == S_LAST);
    assign bit_boundary = tick && (s == S_WRAP);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with valid/ready output stream.
//   clk, rst       - clock, synchronous active-high reset
//   tick           - oversampling enable, OVERSAMPLE per bit
//   rx             - asynchronous serial input, idles high
//   cfg_data_bits  - data length (clamped to 5..MAX_DATA_BITS), latched at start detection
//   cfg_parity     - 0 none, 1 even, 2 odd, 3 none
//   cfg_stop2      - two stop bits
//   stream         - output word + flags (valid/ready)
//   overrun        - one-clk pulse when a completed word is dropped
//   busy           - receiver not idle
module uart_rx_cfg
    import uart_cfg_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                rx,
    input  logic [3:0]          cfg_data_bits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    uart_rx_cfg_if.master       stream,
    output logic                overrun,
    output logic                busy
);

    localparam int CW = $clog2(OVERSAMPLE);

    logic rxs, bit_value, bit_strobe, bit_boundary, restart;

    uart_bit_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .rx           (rx),
        .restart      (restart),
        .rxs          (rxs),
        .bit_value    (bit_value),
        .bit_strobe   (bit_strobe),
        .bit_boundary (bit_boundary)
    );

    rx_state_e                state_q, state_n;
    logic [3:0]               len_q, len_n;
    parity_e                  par_q, par_n;
    logic                     stop2_q, stop2_n;
    logic [3:0]               idx_q, idx_n;
    logic [MAX_DATA_BITS-1:0] data_q, data_n;
    logic                     par_acc_q, par_acc_n;
    logic                     zero_q, zero_n;      // every bit so far was 0 (break candidate)
    rx_status_t               status_q, status_n;
    logic [CW-1:0]            brk_cnt_q, brk_cnt_n;
    logic                     complete;

    logic                     valid_q;
    logic [MAX_DATA_BITS-1:0] out_data_q;
    rx_status_t               out_status_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= 4'(DATA_BITS_MIN);
            par_q     <= PAR_NONE;
            stop2_q   <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
            par_acc_q <= 1'b0;
            zero_q    <= 1'b0;
            status_q  <= '0;
            brk_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            len_q     <= len_n;
            par_q     <= par_n;
            stop2_q   <= stop2_n;
            idx_q     <= idx_n;
            data_q    <= data_n;
            par_acc_q <= par_acc_n;
            zero_q    <= zero_n;
            status_q  <= status_n;
            brk_cnt_q <= brk_cnt_n;
        end
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state_q;
        len_n     = len_q;
        par_n     = par_q;
        stop2_n   = stop2_q;
        idx_n     = idx_q;
        data_n    = data_q;
        par_acc_n = par_acc_q;
        zero_n    = zero_q;
        status_n  = status_q;
        brk_cnt_n = brk_cnt_q;
        restart   = 1'b0;
        complete  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && !rxs) begin
                    state_n   = ST_START;
                    restart   = 1'b1;
                    len_n     = clamp_data_bits(cfg_data_bits, MAX_DATA_BITS);
                    par_n     = decode_parity(cfg_parity);
                    stop2_n   = cfg_stop2;
                    idx_n     = '0;
                    data_n    = '0;
                    par_acc_n = 1'b0;
                    zero_n    = 1'b1;
                    status_n  = '0;
                end
            end
            ST_START: begin
                // A high majority means a glitch, not a start bit.
                if (bit_strobe && bit_value)
                    state_n = ST_IDLE;
                else if (bit_boundary)
                    state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    data_n    = data_q | (MAX_DATA_BITS'(bit_value) << idx_q);
                    par_acc_n = par_acc_q ^ bit_value;
                    zero_n    = zero_q & ~bit_value;
                end
                if (bit_boundary) begin
                    if (idx_q == len_q - 4'd1) begin
                        idx_n   = '0;
                        state_n = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        idx_n = idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe) begin
                    status_n.parity_err = (par_q == PAR_ODD) ? ~(par_acc_q ^ bit_value)
                                                             :  (par_acc_q ^ bit_value);
                    zero_n = zero_q & ~bit_value;
                end
                if (bit_boundary) begin
                    idx_n   = '0;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    if (!bit_value) status_n.frame_err = 1'b1;
                    if (idx_q == 4'd0 && !bit_value && zero_q) status_n.brk = 1'b1;
                    // Finish mid-way through the last stop bit to leave room for resync.
                    if (idx_q == {3'b000, stop2_q}) begin
                        complete  = 1'b1;
                        brk_cnt_n = '0;
                        state_n   = status_n.brk ? ST_BRK_WAIT : ST_IDLE;
                    end
                end else if (bit_boundary) begin
                    idx_n = idx_q + 4'd1;
                end
            end
            ST_BRK_WAIT: begin
                if (tick) begin
                    if (!rxs) begin
                        brk_cnt_n = '0;
                    end else if (brk_cnt_q == CW'(OVERSAMPLE - 1)) begin
                        brk_cnt_n = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        brk_cnt_n = brk_cnt_q + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output holding register: a completing word is dropped if the previous one is still unread.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            out_data_q   <= '0;
            out_status_q <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete) begin
                if (valid_q && !stream.out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    valid_q      <= 1'b1;
                    out_data_q   <= data_n;
                    out_status_q <= status_n;
                end
            end else if (valid_q && stream.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign stream.out_valid      = valid_q;
    assign stream.out_data       = out_data_q;
    assign stream.out_parity_err = out_status_q.parity_err;
    assign stream.out_frame_err  = out_status_q.frame_err;
    assign stream.out_break      = out_status_q.brk;
    assign busy                  = (state_q != ST_IDLE);

endmodule
